// File: rtl/pkt_slot_buf.sv
// pkt_slot_buf: slot-based packet input buffer.
// Packet metadata and tagged packet words are queued in show-ahead FIFOs.
// A free slot is taken for each packet. The words are written into the slot
// RAM at {slot, word}. A descriptor {slot, trunc_err, meta} is then emitted
// to the scheduler. Zero-length packets are discarded. Packets longer than a
// slot are truncated. The two statistics counters saturate.
//
// Ports:
//   clk, reset (async, active-low)
//   meta_in_valid/meta_in         : metadata write into the metadata FIFO
//   data_in_valid/data_in         : tagged word write into the data FIFO
//   data_in_usedw                 : data FIFO fill level
//   free_slot_wr/free_slot        : slot returned to the free list by the consumer
//   meta_out_valid/ready/meta_out : descriptor handshake to the scheduler
//   ram_rd/ram_rd_addr/ram_q      : registered slot RAM read port
//   cnt_zero_drop, cnt_trunc      : saturating packet statistics
//   ovf_flag                      : sticky, set by a write into any full FIFO

module pkt_slot_buf_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_i,
  input  logic [W-1:0]  din_i,
  input  logic          rd_i,
  output logic [W-1:0]  dout_o,
  output logic          empty_o,
  output logic [AW:0]   count_o,
  output logic          ovf_o
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic          full, do_wr, do_rd;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_wr   = wr_i & ~full;
  assign do_rd   = rd_i & ~empty_o;
  assign ovf_o   = wr_i & full;
  assign dout_o  = mem[rptr_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + 1'b1;
      if (do_rd) rptr_q <= rptr_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

module pkt_slot_buf #(
  parameter int DW        = 139,
  parameter int MW        = 360,
  parameter int META_KEEP = 336,
  parameter int LEN_LSB   = 328,
  parameter int LEN_W     = 8,
  parameter int SLOT_AW   = 4,
  parameter int WORD_AW   = 7,
  parameter int DATA_AW   = 8,
  parameter int META_AW   = 6
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           meta_in_valid,
  input  logic [MW-1:0]                  meta_in,
  input  logic                           data_in_valid,
  input  logic [DW-1:0]                  data_in,
  output logic [DATA_AW-1:0]             data_in_usedw,
  input  logic                           free_slot_wr,
  input  logic [SLOT_AW-1:0]             free_slot,
  output logic                           meta_out_valid,
  input  logic                           meta_out_ready,
  output logic [SLOT_AW+META_KEEP:0]     meta_out,
  input  logic                           ram_rd,
  input  logic [SLOT_AW+WORD_AW-1:0]     ram_rd_addr,
  output logic [DW-1:0]                  ram_q,
  output logic [15:0]                    cnt_zero_drop,
  output logic [15:0]                    cnt_trunc,
  output logic                           ovf_flag
);
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_LOOK, S_XFER, S_DRAIN, S_EMIT} state_t;

  localparam logic [2:0] TAG_TAIL = 3'b110;

  state_t                  state_q;
  logic [3:0]              init_cnt_q;
  logic [META_KEEP-1:0]    meta_q;
  logic                    len_zero_q;
  logic [SLOT_AW-1:0]      slot_q;
  logic [WORD_AW-1:0]      idx_q;
  logic                    trunc_q, emit_q;

  logic [MW-1:0]           meta_head;
  logic [DW-1:0]           data_head;
  logic [SLOT_AW-1:0]      free_head;
  logic                    meta_empty, data_empty, free_empty;
  logic [META_AW:0]        meta_cnt;
  logic [DATA_AW:0]        data_cnt;
  logic [SLOT_AW:0]        free_cnt;
  logic                    meta_ovf, data_ovf, free_ovf;
  logic                    meta_pop, data_pop, free_pop, data_tail, ram_we;

  logic [DW-1:0]           ram [1 << (SLOT_AW+WORD_AW)];

  logic                    unused_sig;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  pkt_slot_buf_fifo #(.W(MW), .AW(META_AW)) u_meta_fifo (
    .clk(clk), .rst_n(reset), .wr_i(meta_in_valid), .din_i(meta_in),
    .rd_i(meta_pop), .dout_o(meta_head), .empty_o(meta_empty),
    .count_o(meta_cnt), .ovf_o(meta_ovf)
  );

  pkt_slot_buf_fifo #(.W(DW), .AW(DATA_AW)) u_data_fifo (
    .clk(clk), .rst_n(reset), .wr_i(data_in_valid), .din_i(data_in),
    .rd_i(data_pop), .dout_o(data_head), .empty_o(data_empty),
    .count_o(data_cnt), .ovf_o(data_ovf)
  );

  pkt_slot_buf_fifo #(.W(SLOT_AW), .AW(SLOT_AW)) u_free_fifo (
    .clk(clk), .rst_n(reset), .wr_i(free_slot_wr), .din_i(free_slot),
    .rd_i(free_pop), .dout_o(free_head), .empty_o(free_empty),
    .count_o(free_cnt), .ovf_o(free_ovf)
  );

  // A completely full data FIFO reads as all-ones, because the level
  // 2^DATA_AW does not fit in DATA_AW bits.
  assign data_in_usedw = data_cnt[DATA_AW] ? '1 : data_cnt[DATA_AW-1:0];

  assign unused_sig = ^{meta_head[MW-1:META_KEEP], meta_cnt, free_cnt};

  assign data_tail = (data_head[DW-1 -: 3] == TAG_TAIL);
  assign meta_pop  = (state_q == S_IDLE) & ~meta_empty;
  assign free_pop  = (state_q == S_LOOK) & ~len_zero_q & ~free_empty;
  assign data_pop  = ((state_q == S_XFER) | (state_q == S_DRAIN)) & ~data_empty;
  assign ram_we    = (state_q == S_XFER) & ~data_empty;

  always_ff @(posedge clk) begin
    if (ram_we) ram[{slot_q, idx_q}] <= data_head;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ram_q <= '0;
    end else if (ram_rd) begin
      ram_q <= ram[ram_rd_addr];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_flag <= 1'b0;
    end else if (meta_ovf | data_ovf | free_ovf) begin
      ovf_flag <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_INIT;
      init_cnt_q     <= '0;
      meta_q         <= '0;
      len_zero_q     <= 1'b0;
      slot_q         <= '0;
      idx_q          <= '0;
      trunc_q        <= 1'b0;
      emit_q         <= 1'b0;
      meta_out_valid <= 1'b0;
      meta_out       <= '0;
      cnt_zero_drop  <= '0;
      cnt_trunc      <= '0;
    end else begin
      case (state_q)
        S_INIT: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == 4'd15) state_q <= S_IDLE;
        end
        S_IDLE: begin
          if (meta_pop) begin
            meta_q     <= meta_head[META_KEEP-1:0];
            len_zero_q <= (meta_head[LEN_LSB +: LEN_W] == '0);
            state_q    <= S_LOOK;
          end
        end
        S_LOOK: begin
          // Zero-length packets never take a slot; their words are still drained.
          if (len_zero_q) begin
            cnt_zero_drop <= sat_inc(cnt_zero_drop);
            emit_q        <= 1'b0;
            state_q       <= S_DRAIN;
          end else if (!free_empty) begin
            slot_q  <= free_head;
            idx_q   <= '0;
            trunc_q <= 1'b0;
            state_q <= S_XFER;
          end
        end
        S_XFER: begin
          if (!data_empty) begin
            if (data_tail) begin
              meta_out       <= {slot_q, trunc_q, meta_q};
              meta_out_valid <= 1'b1;
              state_q        <= S_EMIT;
            end else if (idx_q == '1) begin
              // Slot is full, but the packet has no tail yet.
              trunc_q   <= 1'b1;
              cnt_trunc <= sat_inc(cnt_trunc);
              emit_q    <= 1'b1;
              state_q   <= S_DRAIN;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (!data_empty && data_tail) begin
            if (emit_q) begin
              meta_out       <= {slot_q, trunc_q, meta_q};
              meta_out_valid <= 1'b1;
              state_q        <= S_EMIT;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        S_EMIT: begin
          if (meta_out_ready) begin
            meta_out_valid <= 1'b0;
            state_q        <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pkt_slot_buf.sv
// Directed testbench for pkt_slot_buf.
module tb_pkt_slot_buf;
  localparam int DW  = 139;
  localparam int MW  = 360;
  localparam int MK  = 336;
  localparam int SAW = 4;
  localparam int WAW = 7;
  localparam int DAW = 8;
  localparam int OW  = SAW + 1 + MK;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              meta_in_valid = 1'b0;
  logic [MW-1:0]     meta_in = '0;
  logic              data_in_valid = 1'b0;
  logic [DW-1:0]     data_in = '0;
  logic [DAW-1:0]    data_in_usedw;
  logic              free_slot_wr = 1'b0;
  logic [SAW-1:0]    free_slot = '0;
  logic              meta_out_valid;
  logic              meta_out_ready = 1'b1;
  logic [OW-1:0]     meta_out;
  logic              ram_rd = 1'b0;
  logic [SAW+WAW-1:0] ram_rd_addr = '0;
  logic [DW-1:0]     ram_q;
  logic [15:0]       cnt_zero_drop, cnt_trunc;
  logic              ovf_flag;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pkt_slot_buf dut (
    .clk(clk), .reset(reset),
    .meta_in_valid(meta_in_valid), .meta_in(meta_in),
    .data_in_valid(data_in_valid), .data_in(data_in),
    .data_in_usedw(data_in_usedw),
    .free_slot_wr(free_slot_wr), .free_slot(free_slot),
    .meta_out_valid(meta_out_valid), .meta_out_ready(meta_out_ready),
    .meta_out(meta_out),
    .ram_rd(ram_rd), .ram_rd_addr(ram_rd_addr), .ram_q(ram_q),
    .cnt_zero_drop(cnt_zero_drop), .cnt_trunc(cnt_trunc), .ovf_flag(ovf_flag)
  );

  function automatic logic [MW-1:0] mk_meta(input logic [7:0] len, input logic [31:0] seed);
    logic [MW-1:0] m;
    m = {seed[7:0], {11{seed}}};
    m[335:328] = len;
    return m;
  endfunction

  function automatic logic [DW-1:0] mk_word(input logic [2:0] tag, input logic [31:0] v);
    return {tag, {4{v}}, v[7:0]};
  endfunction

  function automatic logic [2:0] tag_of(input int i, input int n);
    if (i == 0) return 3'b101;
    if (i == n - 1) return 3'b110;
    return 3'b100;
  endfunction

  function automatic logic [SAW+WAW-1:0] addr(input int s, input int w);
    return {SAW'(s), WAW'(w)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    data_in = w;
    data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
  endtask

  task automatic push_pkt(input int n, input logic [31:0] seed);
    for (int i = 0; i < n; i++) push_word(mk_word(tag_of(i, n), seed + 32'(i)));
  endtask

  task automatic push_meta(input logic [MW-1:0] m);
    meta_in = m;
    meta_in_valid = 1'b1;
    tick();
    meta_in_valid = 1'b0;
  endtask

  task automatic ret_slot(input int s);
    free_slot = SAW'(s);
    free_slot_wr = 1'b1;
    tick();
    free_slot_wr = 1'b0;
  endtask

  task automatic rd_ram(input logic [SAW+WAW-1:0] a, output logic [DW-1:0] q);
    ram_rd = 1'b1;
    ram_rd_addr = a;
    tick();
    q = ram_q;
    ram_rd = 1'b0;
  endtask

  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      if (meta_out_valid === 1'b1) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    n_chk++; if (meta_out_valid !== 1'b0) $display("FAIL rst_valid got=%0b exp=0", meta_out_valid); else n_pass++;
    n_chk++; if (meta_out !== '0) $display("FAIL rst_meta_out got=%h exp=0", meta_out); else n_pass++;
    n_chk++; if (ram_q !== '0) $display("FAIL rst_ram_q got=%h exp=0", ram_q); else n_pass++;
    n_chk++; if (cnt_zero_drop !== 16'd0) $display("FAIL rst_cnt_zero got=%0d exp=0", cnt_zero_drop); else n_pass++;
    n_chk++; if (cnt_trunc !== 16'd0) $display("FAIL rst_cnt_trunc got=%0d exp=0", cnt_trunc); else n_pass++;
    n_chk++; if (ovf_flag !== 1'b0) $display("FAIL rst_ovf got=%0b exp=0", ovf_flag); else n_pass++;
    n_chk++; if (data_in_usedw !== '0) $display("FAIL rst_usedw got=%0d exp=0", data_in_usedw); else n_pass++;
    reset = 1'b1;
    repeat (16) tick();
  endtask

  task automatic test_basic();
    logic [MW-1:0] m;
    logic [OW-1:0] exp;
    logic [DW-1:0] q;
    ret_slot(3);
    ret_slot(7);
    push_pkt(4, 32'h1000);
    m = mk_meta(8'd4, 32'hA5A50001);
    meta_out_ready = 1'b1;
    push_meta(m);
    repeat (5) tick();
    n_chk++; if (meta_out_valid !== 1'b0) $display("FAIL lat_early got=%0b exp=0", meta_out_valid); else n_pass++;
    tick();
    n_chk++; if (meta_out_valid !== 1'b1) $display("FAIL lat_valid got=%0b exp=1", meta_out_valid); else n_pass++;
    exp = {4'd3, 1'b0, m[MK-1:0]};
    n_chk++; if (meta_out !== exp) $display("FAIL basic_meta got=%h exp=%h", meta_out, exp); else n_pass++;
    tick();
    n_chk++; if (meta_out_valid !== 1'b0) $display("FAIL lat_drop got=%0b exp=0", meta_out_valid); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      rd_ram(addr(3, i), q);
      n_chk++;
      if (q !== mk_word(tag_of(i, 4), 32'h1000 + 32'(i)))
        $display("FAIL basic_ram%0d got=%h exp=%h", i, q, mk_word(tag_of(i, 4), 32'h1000 + 32'(i)));
      else n_pass++;
    end
  endtask

  task automatic test_zero_drop();
    logic [MW-1:0] m;
    logic [OW-1:0] exp;
    logic [DW-1:0] q;
    bit seen, ok;
    ret_slot(3);
    push_pkt(2, 32'h2000);
    push_meta(mk_meta(8'd0, 32'h0BAD0000));
    seen = 1'b0;
    repeat (12) begin
      tick();
      if (meta_out_valid === 1'b1) seen = 1'b1;
    end
    n_chk++; if (seen !== 1'b0) $display("FAIL zd_no_out got=%0b exp=0", seen); else n_pass++;
    n_chk++; if (cnt_zero_drop !== 16'd1) $display("FAIL zd_cnt got=%0d exp=1", cnt_zero_drop); else n_pass++;
    n_chk++; if (data_in_usedw !== '0) $display("FAIL zd_drained got=%0d exp=0", data_in_usedw); else n_pass++;
    rd_ram(addr(7, 0), q);
    n_chk++; if (q === mk_word(3'b101, 32'h2000)) $display("FAIL zd_nowrite got=%h exp=not_written", q); else n_pass++;
    push_pkt(2, 32'h2100);
    m = mk_meta(8'd2, 32'h22220000);
    push_meta(m);
    wait_valid(20, ok);
    n_chk++; if (!ok) $display("FAIL zd_next_timeout got=0 exp=1"); else n_pass++;
    exp = {4'd7, 1'b0, m[MK-1:0]};
    n_chk++; if (meta_out !== exp) $display("FAIL zd_next_meta got=%h exp=%h", meta_out, exp); else n_pass++;
    tick();
    rd_ram(addr(7, 1), q);
    n_chk++; if (q !== mk_word(3'b110, 32'h2101)) $display("FAIL zd_next_ram got=%h exp=%h", q, mk_word(3'b110, 32'h2101)); else n_pass++;
  endtask

  task automatic test_trunc();
    logic [MW-1:0] m;
    logic [OW-1:0] exp;
    logic [DW-1:0] q;
    bit ok;
    push_pkt(130, 32'h3000);
    m = mk_meta(8'd130, 32'h33330000);
    push_meta(m);
    wait_valid(200, ok);
    n_chk++; if (!ok) $display("FAIL tr_timeout got=0 exp=1"); else n_pass++;
    exp = {4'd3, 1'b1, m[MK-1:0]};
    n_chk++; if (meta_out !== exp) $display("FAIL tr_meta got=%h exp=%h", meta_out, exp); else n_pass++;
    n_chk++; if (cnt_trunc !== 16'd1) $display("FAIL tr_cnt got=%0d exp=1", cnt_trunc); else n_pass++;
    tick();
    n_chk++; if (data_in_usedw !== '0) $display("FAIL tr_drained got=%0d exp=0", data_in_usedw); else n_pass++;
    rd_ram(addr(3, 0), q);
    n_chk++; if (q !== mk_word(3'b101, 32'h3000)) $display("FAIL tr_ram0 got=%h exp=%h", q, mk_word(3'b101, 32'h3000)); else n_pass++;
    rd_ram(addr(3, 127), q);
    n_chk++; if (q !== mk_word(3'b100, 32'h3000 + 32'd127)) $display("FAIL tr_ram127 got=%h exp=%h", q, mk_word(3'b100, 32'h3000 + 32'd127)); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [MW-1:0] ma, mb;
    logic [OW-1:0] exp;
    bit ok, stable;
    ret_slot(3);
    ret_slot(7);
    meta_out_ready = 1'b0;
    push_pkt(2, 32'h4000);
    push_pkt(2, 32'h4100);
    ma = mk_meta(8'd2, 32'h44440000);
    mb = mk_meta(8'd2, 32'h45450000);
    push_meta(ma);
    push_meta(mb);
    wait_valid(20, ok);
    n_chk++; if (!ok) $display("FAIL bp_timeout got=0 exp=1"); else n_pass++;
    exp = {4'd3, 1'b0, ma[MK-1:0]};
    n_chk++; if (meta_out !== exp) $display("FAIL bp_meta_a got=%h exp=%h", meta_out, exp); else n_pass++;
    stable = 1'b1;
    repeat (10) begin
      tick();
      if (meta_out_valid !== 1'b1 || meta_out !== exp) stable = 1'b0;
    end
    n_chk++; if (stable !== 1'b1) $display("FAIL bp_stable got=%0b exp=1", stable); else n_pass++;
    n_chk++; if (data_in_usedw !== 8'd2) $display("FAIL bp_held_words got=%0d exp=2", data_in_usedw); else n_pass++;
    meta_out_ready = 1'b1;
    tick();
    n_chk++; if (meta_out_valid !== 1'b0) $display("FAIL bp_accept got=%0b exp=0", meta_out_valid); else n_pass++;
    wait_valid(20, ok);
    n_chk++; if (!ok) $display("FAIL bp_b_timeout got=0 exp=1"); else n_pass++;
    exp = {4'd7, 1'b0, mb[MK-1:0]};
    n_chk++; if (meta_out !== exp) $display("FAIL bp_meta_b got=%h exp=%h", meta_out, exp); else n_pass++;
    tick();
  endtask

  task automatic test_no_slot();
    logic [MW-1:0] m;
    logic [OW-1:0] exp;
    logic [DW-1:0] q;
    bit ok, seen;
    push_pkt(2, 32'h5000);
    m = mk_meta(8'd2, 32'h55550000);
    push_meta(m);
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (meta_out_valid === 1'b1) seen = 1'b1;
    end
    n_chk++; if (seen !== 1'b0) $display("FAIL ns_stall_out got=%0b exp=0", seen); else n_pass++;
    n_chk++; if (data_in_usedw !== 8'd2) $display("FAIL ns_no_pop got=%0d exp=2", data_in_usedw); else n_pass++;
    ret_slot(5);
    wait_valid(20, ok);
    n_chk++; if (!ok) $display("FAIL ns_timeout got=0 exp=1"); else n_pass++;
    exp = {4'd5, 1'b0, m[MK-1:0]};
    n_chk++; if (meta_out !== exp) $display("FAIL ns_meta got=%h exp=%h", meta_out, exp); else n_pass++;
    tick();
    rd_ram(addr(5, 0), q);
    n_chk++; if (q !== mk_word(3'b101, 32'h5000)) $display("FAIL ns_ram0 got=%h exp=%h", q, mk_word(3'b101, 32'h5000)); else n_pass++;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 256; i++) push_word(mk_word(3'b100, 32'(i)));
    n_chk++; if (ovf_flag !== 1'b0) $display("FAIL ov_early got=%0b exp=0", ovf_flag); else n_pass++;
    n_chk++; if (data_in_usedw !== 8'd255) $display("FAIL ov_usedw got=%0d exp=255", data_in_usedw); else n_pass++;
    push_word(mk_word(3'b100, 32'd256));
    n_chk++; if (ovf_flag !== 1'b1) $display("FAIL ov_set got=%0b exp=1", ovf_flag); else n_pass++;
    repeat (5) tick();
    n_chk++; if (ovf_flag !== 1'b1) $display("FAIL ov_sticky got=%0b exp=1", ovf_flag); else n_pass++;
    reset = 1'b0;
    #1;
    n_chk++; if (ovf_flag !== 1'b0) $display("FAIL ov_reset got=%0b exp=0", ovf_flag); else n_pass++;
    n_chk++; if (data_in_usedw !== '0) $display("FAIL ov_reset_usedw got=%0d exp=0", data_in_usedw); else n_pass++;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_zero_drop();
    test_trunc();
    test_backpressure();
    test_no_slot();
    test_overflow();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
